// File: rtl/fp_alu_pkg.sv
// Shared FP ALU definitions: adder op encodings and the pipeline-depth helper
// used to size the segmented mantissa adder.
package fp_alu_pkg;

  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

  // Number of SEG-bit slices needed to cover WIDTH bits; the last may be narrower.
  function automatic int nstg(input int width, input int seg);
    return (width + seg - 1) / seg;
  endfunction

endpackage

// File: rtl/seg_pipe_add_seg_add.sv
// Combinational slice adder for the segmented pipeline, built as a ripple of
// full_add cells.
module full_add (
  output logic s,
  output logic co,
  input  logic a,
  input  logic b,
  input  logic ci
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module seg_add #(
  parameter int W = 4
) (
  output logic [W-1:0] sum,
  output logic         cout,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin
);
  logic [W:0] carry;

  assign carry[0] = cin;
  assign cout     = carry[W];

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_add u_fa (
      .s (sum[i]),
      .co(carry[i+1]),
      .a (a[i]),
      .b (b[i]),
      .ci(carry[i])
    );
  end
endmodule

// File: rtl/seg_pipe_add.sv
// Pipelined carry-segmented adder/subtractor: one SEG-bit slice per stage with a
// registered carry between stages and a valid/ready handshake on both sides.
module seg_pipe_add
  import fp_alu_pkg::*;
#(
  parameter int WIDTH = 13,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTG = nstg(WIDTH, SEG);

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  logic [WIDTH-1:0] a_q   [NSTG];
  logic [WIDTH-1:0] b_q   [NSTG];
  logic [WIDTH-1:0] s_q   [NSTG];
  logic [WIDTH-1:0] slc   [NSTG];
  logic             co_w  [NSTG];
  logic             c_q   [NSTG];
  logic             v_q   [NSTG];

  // Subtract folds into the operands at accept, so the pipe only ever adds.
  assign b_eff = (sub == ALU_OP_SUB) ? ~b : b;
  assign c_eff = (sub == ALU_OP_SUB) ? 1'b1 : cin;

  assign adv      = !v_q[NSTG-1] | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    localparam int LO = k * SEG;
    localparam int W  = (WIDTH - LO < SEG) ? (WIDTH - LO) : SEG;

    logic [W-1:0] sa;
    logic [W-1:0] sb;
    logic [W-1:0] ss;
    logic         ci;

    if (k == 0) begin : g_first
      assign sa = a[LO +: W];
      assign sb = b_eff[LO +: W];
      assign ci = c_eff;
    end else begin : g_rest
      assign sa = a_q[k-1][LO +: W];
      assign sb = b_q[k-1][LO +: W];
      assign ci = c_q[k-1];
    end

    seg_add #(.W(W)) u_seg (
      .sum (ss),
      .cout(co_w[k]),
      .a   (sa),
      .b   (sb),
      .cin (ci)
    );

    // Slice result positioned in the full word; bits above it are still zero upstream.
    assign slc[k] = WIDTH'(ss) << LO;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSTG; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (adv) begin
      v_q[0] <= in_valid;
      c_q[0] <= co_w[0];
      a_q[0] <= a;
      b_q[0] <= b_eff;
      s_q[0] <= slc[0];
      for (int k = 1; k < NSTG; k++) begin
        v_q[k] <= v_q[k-1];
        c_q[k] <= co_w[k];
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
        s_q[k] <= s_q[k-1] | slc[k];
      end
    end
  end

  assign out_valid = v_q[NSTG-1];
  assign sum       = s_q[NSTG-1];
  assign cout      = c_q[NSTG-1];
  assign ovf       = (a_q[NSTG-1][WIDTH-1] == b_q[NSTG-1][WIDTH-1]) &
                     (s_q[NSTG-1][WIDTH-1] != a_q[NSTG-1][WIDTH-1]);

endmodule
